// File: rtl/ab_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package ab_div_pkg;

  // Control states: waiting, iterating one quotient bit per clock, result cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int unsigned DIV_WIDTH_DEFAULT = 8;

  // Fill bit for the quotient on a divide-by-zero: every quotient bit is set
  // (quotient = '1, the saturated "infinite" result); the remainder carries
  // the untouched dividend so the caller can still recover the operand.
  localparam bit DIV_ZERO_Q = 1'b1;

  // Step counter width: enough bits to count 0 .. width-1, never narrower than 1.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {R,Q} left, try R - D,
// keep the difference and set the quotient bit when it does not borrow.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH+1:0] w_r_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;

  // Trial subtraction one bit wider than R so its MSB is a clean borrow flag;
  // R < D always holds between steps, so the shifted value never overflows.
  always_comb begin
    w_r_sh   = {i_r, i_q[WIDTH-1]};
    w_diff   = w_r_sh - {2'b00, i_d};
    w_borrow = w_diff[WIDTH+1];
    o_r      = w_borrow ? w_r_sh[WIDTH:0] : w_diff[WIDTH:0];
    o_q      = {i_q[WIDTH-2:0], ~w_borrow};
  end

endmodule

// File: rtl/ab_divider.sv
// Sequential unsigned restoring divider: quotient = dividend / divisor,
// remainder = dividend % divisor, one quotient bit per clock with a
// start/busy/done handshake. Divide-by-zero skips iteration entirely.
module ab_divider
  import ab_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned       CNT_W    = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  div_state_t       w_state_next;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic             w_div_zero;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_r_next),
    .o_q (w_q_next)
  );

  // Handshake qualifiers: a start is only honoured outside CALC.
  always_comb begin
    w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    w_last     = (r_state == CALC) && (r_cnt == LAST_CNT);
    w_div_zero = (divisor == '0);
  end

  // State register plus datapath/result registers; reset aborts any divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_q   <= dividend;
        r_r   <= '0;
        r_d   <= divisor;
        r_cnt <= '0;
        // A zero divisor produces its result on the capture edge itself, so
        // results are written here instead of waiting for a last step.
        if (w_div_zero) begin
          r_dbz       <= 1'b1;
          r_quotient  <= {WIDTH{DIV_ZERO_Q}};
          r_remainder <= dividend;
        end else begin
          r_dbz <= 1'b0;
        end
      end else if (r_state == CALC) begin
        r_q   <= w_q_next;
        r_r   <= w_r_next;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_quotient  <= w_q_next;
          r_remainder <= w_r_next[WIDTH-1:0];
        end
      end
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_state_next = w_div_zero ? DONE : CALC;
        end else begin
          w_state_next = IDLE;
        end
      end
      CALC: begin
        w_state_next = w_last ? DONE : CALC;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Moore outputs; busy and done are decoded from disjoint states.
  always_comb begin
    busy        = (r_state == CALC);
    done        = (r_state == DONE);
    quotient    = r_quotient;
    remainder   = r_remainder;
    div_by_zero = r_dbz;
  end

endmodule

// File: tb/tb_ab_divider.sv
// Directed bench for ab_divider: expected results are queued when a divide
// is started and checked by a monitor whenever done pulses.
module tb_ab_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t        sb[$];
  int unsigned total  = 0;
  int unsigned bad    = 0;
  int unsigned n_done = 0;

  always #5 clk = ~clk;

  ab_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued result.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      chk("result_pending_at_done", 32'(sb.size() != 0), 1);
      chk("busy_with_done", 32'(busy), 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Start one divide, scramble operands after capture, and check latency and busy.
  task automatic div_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    int unsigned lat;
    int unsigned nbusy;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.q   = (b == 0) ? '1 : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dbz = (b == 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat   = 999;
    nbusy = 0;
    if (done) begin
      lat = 0;
    end else begin
      if (busy) nbusy++;
      for (int k = 1; k <= int'(W) + 4; k++) begin
        @(posedge clk);
        #1;
        if (done) begin
          lat = k;
          break;
        end
        if (busy) nbusy++;
      end
    end
    chk("latency", lat, (b == 0) ? 0 : W);
    chk("busy_cycles", nbusy, (b == 0) ? 0 : W);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int unsigned n0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_quotient", 32'(quotient), 0);
    chk("reset_remainder", 32'(remainder), 0);
    chk("reset_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Basic divide, extremes, dividend < divisor, divide by zero.
    div_op(8'd200, 8'd7);
    idle(2);
    div_op(8'd255, 8'd1);
    idle(1);
    div_op(8'd5, 8'd9);
    idle(1);
    div_op(8'd100, 8'd0);
    idle(2);

    // start held high with operands changing during CALC: one result only.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    sb.push_back('{q: 8'd28, r: 8'd4, dbz: 1'b0});
    @(posedge clk);
    #1;
    dividend = 8'd50;
    divisor  = 8'd5;
    repeat (7) @(posedge clk);
    #1;
    start = 1'b0;
    n0 = n_done;
    repeat (12) @(posedge clk);
    #1;
    chk("held_start_done_count", n_done - n0, 1);
    idle(1);

    // Back-to-back: second start lands in the DONE cycle of the first.
    div_op(8'd200, 8'd7);
    div_op(8'd143, 8'd11);
    idle(2);

    // Reset in the middle of CALC aborts the divide with no done.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_quotient", 32'(quotient), 0);
    chk("abort_remainder", 32'(remainder), 0);
    chk("abort_dbz", 32'(div_by_zero), 0);
    rst = 1'b0;
    n0 = n_done;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_done_count", n_done - n0, 0);

    // Round trip (a*b)/b == a over small factors.
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        div_op(8'(a * b), 8'(b));
      end
    end

    idle(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
